// File: rtl/branch_pkg.sv
// Shared types for the LEGv8 execute-stage branch resolver: condition codes,
// NZCV bit positions and the squash FSM states.
package branch_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: maps a condition code and the NZCV
// register to a pass/fail decision.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so every path drives pass and no latch is inferred.
    pass = 1'b0;
    unique case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !(c && !z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = !(!z && (n == v));
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: NZCV register, B/B.cond/CBZ/CBNZ decision,
// registered redirect and wrong-path squash. Define DELAY_SLOT_EN to replace
// the squash with a one-instruction delay slot.
module branch_resolve
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        set_flags,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        is_b,
  input  logic        is_cbz,
  input  logic        is_cbnz,
  input  logic        is_bcond,
  input  logic [3:0]  cond,
  input  logic [63:0] pc_in,
  input  logic [63:0] br_offset,
  output logic [3:0]  flags_q,
  output logic        br_taken,
  output logic [63:0] br_target,
  output logic        flush
);

  logic        accept;
  logic        bcond_pass;
  logic        taken;
  logic [63:0] target;

  // B.cond sees the flags as they stand before this edge.
  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags_q),
    .pass  (bcond_pass)
  );

  always_comb begin
    taken = 1'b0;
    if (is_b)          taken = 1'b1;
    else if (is_cbz)   taken = alu_zero;
    else if (is_cbnz)  taken = !alu_zero;
    else if (is_bcond) taken = bcond_pass;
  end

  // Wraps silently modulo 2^64.
  assign target = pc_in + br_offset;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (reset) begin
      flags_q   <= 4'b0000;
      br_taken  <= 1'b0;
      br_target <= 64'h0;
    end else begin
      if (accept && set_flags)
        flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      br_taken <= accept && taken;
      if (accept && taken)
        br_target <= target;
    end
  end

`ifdef DELAY_SLOT_EN
  assign accept = valid_in;
  assign flush  = 1'b0;
`else
  state_t state;

  assign accept = valid_in && (state == IDLE);

  // flush is registered alongside the state so it always equals (state == REDIRECT).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flush <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && taken) begin
            state <= REDIRECT;
            flush <= 1'b1;
          end else begin
            state <= IDLE;
            flush <= 1'b0;
          end
        end
        REDIRECT: begin
          state <= IDLE;
          flush <= 1'b0;
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random
// traffic, checked by a scoreboard against a cycle-level behavioural model.
module tb_branch_resolve;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        sf;
    logic        n, z, c, v;
    logic        b, cbz, cbnz, bcond;
    logic [3:0]  cond;
    logic [63:0] pc;
    logic [63:0] off;
  } stim_t;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    logic        flush;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, set_flags;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        is_b, is_cbz, is_cbnz, is_bcond;
  logic [3:0]  cond;
  logic [63:0] pc_in, br_offset;
  logic [3:0]  flags_q;
  logic        br_taken;
  logic [63:0] br_target;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Model state: what the outputs should read after the most recent edge.
  logic [3:0]  m_flags  = '0;
  logic        m_taken  = 1'b0;
  logic [63:0] m_target = '0;
  logic        m_flush  = 1'b0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .set_flags     (set_flags),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .is_b          (is_b),
    .is_cbz        (is_cbz),
    .is_cbnz       (is_cbnz),
    .is_bcond      (is_bcond),
    .cond          (cond),
    .pc_in         (pc_in),
    .br_offset     (br_offset),
    .flags_q       (flags_q),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .flush         (flush)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Conditions come in pairs; the odd code of each pair is the inverse,
  // except the final pair which is always true.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 1'b0, valid: 1'b1, sf: 1'b0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0,
          b: 1'b0, cbz: 1'b0, cbnz: 1'b0, bcond: 1'b0, cond: 4'h0, pc: 64'h0, off: 64'h0};
    return s;
  endfunction

  // Drives one instruction and predicts the outputs after the next rising edge.
  task automatic apply(input stim_t s);
    logic acc, tk;
    exp_t e;
    @(negedge clk);
    reset = s.rst; valid_in = s.valid; set_flags = s.sf;
    alu_negative = s.n; alu_zero = s.z; alu_carry_out = s.c; alu_overflow = s.v;
    is_b = s.b; is_cbz = s.cbz; is_cbnz = s.cbnz; is_bcond = s.bcond;
    cond = s.cond; pc_in = s.pc; br_offset = s.off;
    if (s.rst) begin
      m_flags = '0; m_taken = 1'b0; m_target = '0; m_flush = 1'b0;
    end else begin
`ifdef DELAY_SLOT_EN
      acc = s.valid;
`else
      acc = s.valid && !m_flush;
`endif
      if (s.b)          tk = 1'b1;
      else if (s.cbz)   tk = s.z;
      else if (s.cbnz)  tk = !s.z;
      else if (s.bcond) tk = cond_true(s.cond, m_flags);
      else              tk = 1'b0;
      if (acc && s.sf) m_flags = {s.n, s.z, s.c, s.v};
      m_taken = acc && tk;
      if (m_taken) m_target = s.pc + s.off;
`ifdef DELAY_SLOT_EN
      m_flush = 1'b0;
`else
      m_flush = m_taken;
`endif
    end
    e = '{taken: m_taken, target: m_target, flush: m_flush, flags: m_flags};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flags_q",   64'(flags_q),   64'(e.flags));
        check("br_taken",  64'(br_taken),  64'(e.taken));
        check("br_target", br_target,      e.target);
        check("flush",     64'(flush),     64'(e.flush));
      end
    end
  end

  initial begin : driver
    stim_t s;
    int    budget;
    reset = 1'b1; valid_in = 1'b0; set_flags = 1'b0;
    alu_negative = 1'b0; alu_zero = 1'b0; alu_carry_out = 1'b0; alu_overflow = 1'b0;
    is_b = 1'b0; is_cbz = 1'b0; is_cbnz = 1'b0; is_bcond = 1'b0;
    cond = 4'h0; pc_in = 64'h0; br_offset = 64'h0;

    s = nop(); s.rst = 1'b1; s.valid = 1'b0;
    apply(s); apply(s);

    // SUBS producing N0 Z1 C1 V0, then a non-flag-setter with noisy ALU flags.
    s = nop(); s.sf = 1'b1; s.z = 1'b1; s.c = 1'b1; apply(s);
    s = nop(); s.n = 1'b1; s.v = 1'b1; apply(s);

    // B.EQ taken to 0x140, then a squashed flag-setter + B in the flush cycle.
    s = nop(); s.bcond = 1'b1; s.cond = 4'b0000; s.pc = 64'h100; s.off = 64'h40; apply(s);
    s = nop(); s.sf = 1'b1; s.n = 1'b1; s.b = 1'b1; s.pc = 64'h200; s.off = 64'h8; apply(s);
    apply(nop());

    // Signed conditions.
    s = nop(); s.sf = 1'b1; s.n = 1'b1; s.v = 1'b1; apply(s);
    s = nop(); s.bcond = 1'b1; s.cond = 4'b1010; s.pc = 64'h300; s.off = 64'h10; apply(s);
    apply(nop());
    s = nop(); s.bcond = 1'b1; s.cond = 4'b1011; s.pc = 64'h400; s.off = 64'h10; apply(s);
    s = nop(); s.sf = 1'b1; s.n = 1'b1; s.z = 1'b1; s.v = 1'b1; apply(s);
    s = nop(); s.bcond = 1'b1; s.cond = 4'b1100; s.pc = 64'h500; s.off = 64'h10; apply(s);

    // CBNZ with target wrap, then reset in the flush cycle and a fresh B.
    s = nop(); s.cbnz = 1'b1; s.pc = 64'hFFFF_FFFF_FFFF_FFF0; s.off = 64'h20; apply(s);
    s = nop(); s.rst = 1'b1; s.b = 1'b1; apply(s);
    s = nop(); s.b = 1'b1; s.pc = 64'h1000; s.off = 64'hFFFF_FFFF_FFFF_FFFC; apply(s);
    apply(nop());

    // Randomized traffic; flag-setters never share a cycle with B.cond.
    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.valid = ($urandom_range(9) != 0);
      s.n = 1'($urandom); s.z = 1'($urandom); s.c = 1'($urandom); s.v = 1'($urandom);
      s.b     = ($urandom_range(7) == 0);
      s.cbz   = ($urandom_range(5) == 0);
      s.cbnz  = ($urandom_range(5) == 0);
      s.bcond = ($urandom_range(2) == 0);
      s.sf    = !s.bcond && ($urandom_range(1) == 0);
      s.cond  = 4'($urandom);
      s.pc    = {$urandom, $urandom};
      s.off   = {$urandom, $urandom};
      s.rst   = ($urandom_range(99) == 0);
      apply(s);
    end
    apply(nop());

    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage consumer of the 64-bit ALU outputs in the pipelined LEGv8 datapath. It holds the architectural NZCV flag register, loaded from the ALU flag outputs by flag-setting instructions. It evaluates B, B.cond, CBZ and CBNZ and produces a registered taken/target redirect for the fetch stage. A two-state FSM squashes the wrong-path instruction after a taken branch unless delay-slot mode is compiled in.

## Interface
- Parameters: none. Widths are fixed at 64-bit data and 4-bit condition code.
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  EX-stage instruction valid
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flag outputs, same cycle as the instruction
- is_b  in  1  unconditional B/BL
- is_cbz, is_cbnz  in  1 each  compare-and-branch; the ALU passes the register through, so alu_zero is the test
- is_bcond  in  1  B.cond
- cond  in  4  condition code for B.cond
- pc_in  in  64  PC of the EX instruction
- br_offset  in  64  sign-extended, word-shifted branch offset
- flags_q  out  4  {N,Z,C,V} register
- br_taken  out  1  registered redirect request
- br_target  out  64  registered redirect address
- flush  out  1  the instruction now in EX is wrong-path and is squashed

## Operation
- accept = valid_in and not squashing (state IDLE, or DELAY_SLOT_EN defined).
- Flag write: on an edge with accept and set_flags, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. Otherwise flags_q holds.
- B.cond evaluates against flags_q as it stands before the edge. A flag-setter and a B.cond in the same cycle cannot occur in the ISA.
- Branch priority when several strobes are asserted: is_b > is_cbz > is_cbnz > is_bcond.
- Taken rules:
  - B: always taken.
  - CBZ: taken when alu_zero. CBNZ: taken when !alu_zero.
  - B.cond conditions: EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !(C&!Z); GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 the inverse of GT; 1110 and 1111 always.
- Target: pc_in + br_offset, modulo 2^64. Wrap is silent and no overflow is flagged.
- FSM states:
  - IDLE: on accept with a taken branch, go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: lasts one cycle, then returns to IDLE. The EX instruction in this cycle is ignored: no flag write, no branch.
- A taken branch seen in REDIRECT is ignored because that branch is itself squashed.

## Timing
- Reset values: flags_q=4'b0000, br_taken=0, br_target=64'h0, flush=0, state IDLE.
- Reset during REDIRECT forces IDLE on the same edge. The pending flush is dropped.
- br_taken and br_target assert one cycle after the branch is in EX and stay for exactly one cycle. br_target holds its last value when br_taken=0.
- flush equals (state==REDIRECT). It is high in the same cycle as br_taken.
- flags_q is visible one cycle after the flag-setting instruction, so B.cond can immediately follow SUBS.
- Back-to-back taken branches in IDLE: the second one lands in REDIRECT and is squashed.

## Configuration
- DELAY_SLOT_EN defined:
  - The REDIRECT state is not built, and flush is tied to 0.
  - The instruction after a taken branch executes normally as a delay slot.
  - If that delay-slot instruction is itself a taken branch, it redirects as well.
- DELAY_SLOT_EN undefined: the one-instruction squash behaviour described above.

## Structure
- Shared package (branch_pkg):
  - the cond_t enum with the 16 codes above;
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the state enum {IDLE, REDIRECT}.
- One combinational sub-module, cond_eval, maps (cond, flags) to pass. The top level holds the registers, the FSM, priority and the target adder.

## Test plan
- Flag capture: SUBS with ALU flags N0 Z1 C1 V0 → next cycle flags_q=4'b0110. The next instruction has set_flags=0 → flags_q holds.
- B.EQ taken: flags_q=0110, pc_in=64'h100, br_offset=64'h40 → next cycle br_taken=1, br_target=64'h140, flush=1 (non-delay-slot build). The following cycle br_taken=0.
- Squash: in the flush cycle apply set_flags with flags 1000 and is_b=1 → flags_q unchanged, no second br_taken.
- Signed conditions: flags_q=1001 (N=V) with GE → taken. LT → not taken. GT with flags_q=1101 → not taken.
- CBNZ and wrap: alu_zero=0, pc_in=64'hFFFF_FFFF_FFFF_FFF0, br_offset=64'h20 → br_taken=1, br_target=64'h10.
- Reset mid-REDIRECT: assert reset in the flush cycle → all outputs 0 next cycle. A valid instruction next is accepted normally.
